// File: rtl/riscv_dmi_arbiter.sv
// Round-robin arbiter sharing one DMI request/response channel between NUM_REQ
// requesters, with a registered request stage and a single outstanding transaction.
module riscv_dmi_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 2,
  localparam int OW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      trst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ*OP_W-1:0]   req_op_i,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  input  logic [NUM_REQ-1:0]        resp_ready_i,
  output logic [DATA_W-1:0]         resp_data_o,
  output logic [OP_W-1:0]           resp_op_o,
  output logic                      dm_req_valid_o,
  input  logic                      dm_req_ready_i,
  output logic [ADDR_W-1:0]         dm_req_addr_o,
  output logic [DATA_W-1:0]         dm_req_data_o,
  output logic [OP_W-1:0]           dm_req_op_o,
  input  logic                      dm_resp_valid_i,
  output logic                      dm_resp_ready_o,
  input  logic [DATA_W-1:0]         dm_resp_data_i,
  input  logic [OP_W-1:0]           dm_resp_op_i,
  output logic                      busy_o,
  output logic [OW-1:0]             owner_o,
  output logic                      stray_resp_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]    state;
  logic [OW-1:0] rr_ptr;
  logic          grant_found;
  logic [OW-1:0] grant_idx;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid_i[(int'(rr_ptr) + i) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = OW'((int'(rr_ptr) + i) % NUM_REQ);
      end else begin
        grant_found = grant_found;
      end
    end
  end

  // Request accept: only in IDLE, and suppressed while reset is held
  always_comb begin
    req_ready_o = '0;
    if (state == S_IDLE && grant_found && !trst_i) begin
      req_ready_o = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
    end else begin
      req_ready_o = '0;
    end
  end

  // Response routing; outside WAIT any DM response is drained
  always_comb begin
    resp_valid_o    = '0;
    resp_data_o     = '0;
    resp_op_o       = '0;
    dm_resp_ready_o = 1'b1;
    if (state == S_WAIT) begin
      resp_valid_o[owner_o] = dm_resp_valid_i;
      resp_data_o           = dm_resp_data_i;
      resp_op_o             = dm_resp_op_i;
      dm_resp_ready_o       = resp_ready_i[owner_o];
    end else begin
      dm_resp_ready_o = 1'b1;
    end
  end

  assign dm_req_valid_o = (state == S_ISSUE);
  assign busy_o         = (state != S_IDLE);

  // Transaction state, captured request fields, ownership and stray flag
  always_ff @(posedge clk_i or posedge trst_i) begin
    if (trst_i) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      owner_o       <= '0;
      stray_resp_o  <= 1'b0;
      dm_req_addr_o <= '0;
      dm_req_data_o <= '0;
      dm_req_op_o   <= '0;
    end else begin
      if (state != S_WAIT && dm_resp_valid_i) begin
        stray_resp_o <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            dm_req_addr_o <= req_addr_i[int'(grant_idx)*ADDR_W +: ADDR_W];
            dm_req_data_o <= req_data_i[int'(grant_idx)*DATA_W +: DATA_W];
            dm_req_op_o   <= req_op_i[int'(grant_idx)*OP_W +: OP_W];
            owner_o       <= grant_idx;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (dm_req_ready_i) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dm_resp_valid_i && resp_ready_i[owner_o]) begin
            rr_ptr <= (owner_o == OW'(NUM_REQ-1)) ? '0 : owner_o + OW'(1);
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
